// File: rtl/dsi_feeder_pkg.sv
// ============================================================================
// dsi_feeder_pkg : shared types and strobe helpers for dsi_payload_feeder
// Revision: 1.0
// ============================================================================
`default_nettype none

package dsi_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    ACTIVE = 2'd2
  } feeder_state_t;

  localparam logic [3:0] STRB_FULL = 4'b1111;

  // Byte-lane mask for the final payload word, keyed by pkt_len[1:0].
  function automatic logic [3:0] last_strb(input logic [1:0] rem);
    logic [3:0] mask;
    case (rem)
      2'd1:    mask = 4'b0001;
      2'd2:    mask = 4'b0011;
      2'd3:    mask = 4'b0111;
      default: mask = STRB_FULL;
    endcase
    return mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dsi_payload_feeder.sv
// ============================================================================
// dsi_payload_feeder : feeds payload words plus lane strobes to the repacker.
// Optional underflow_cnt output enabled by DSI_FEEDER_UNDERFLOW_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dsi_payload_feeder
  import dsi_feeder_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pkt_start,
  input  logic [LEN_W-1:0] pkt_len,
  output logic             pkt_busy,
  output logic             word_ready,
  output logic             pkt_done,
  output logic             underflow,
`ifdef DSI_FEEDER_UNDERFLOW_CNT_EN
  output logic [15:0]      underflow_cnt,
`endif
  input  logic [31:0]      fifo_data,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  input  logic             data_change_req,
  output logic [31:0]      data_out,
  output logic [3:0]       strb_out
);

  localparam int WL_W = LEN_W - 1;

  feeder_state_t   r_state;
  feeder_state_t   w_state_next;
  logic [WL_W-1:0] r_words_left;
  logic [1:0]      r_rem;
  logic [31:0]     r_data;
  logic [3:0]      r_strb;
  logic            r_word_ready;
  logic            r_pkt_done;
  logic            r_underflow;

  logic [WL_W-1:0] w_len_words;
  logic [3:0]      w_sched_strb;
  logic            w_fifo_rd;
  logic            w_load;
  logic [31:0]     w_load_data;
  logic [3:0]      w_load_strb;
  logic            w_dec;
  logic            w_latch;
  logic            w_set_ready;
  logic            w_clr_ready;
  logic            w_done;
  logic            w_underrun;

  // ceil(pkt_len/4) without a wider intermediate adder
  assign w_len_words  = {1'b0, pkt_len[LEN_W-1:2]} + WL_W'(pkt_len[1:0] != 2'b00);
  assign w_sched_strb = (r_words_left == WL_W'(1)) ? last_strb(r_rem) : STRB_FULL;

  always_comb begin
    w_state_next = r_state;
    w_fifo_rd    = 1'b0;
    w_load       = 1'b0;
    w_load_data  = 32'h0;
    w_load_strb  = 4'b0000;
    w_dec        = 1'b0;
    w_latch      = 1'b0;
    w_set_ready  = 1'b0;
    w_clr_ready  = 1'b0;
    w_done       = 1'b0;
    w_underrun   = 1'b0;
    case (r_state)
      IDLE: begin
        if (pkt_start) begin
          if (pkt_len != '0) begin
            w_latch      = 1'b1;
            w_state_next = FILL;
          end else begin
            w_done = 1'b1;
          end
        end
        if (data_change_req) begin
          w_load = 1'b1;
        end
      end
      FILL: begin
        if (!fifo_empty) begin
          w_fifo_rd    = 1'b1;
          w_load       = 1'b1;
          w_load_data  = fifo_data;
          w_load_strb  = w_sched_strb;
          w_dec        = 1'b1;
          w_set_ready  = 1'b1;
          w_state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (data_change_req) begin
          w_load = 1'b1;
          if (r_words_left != '0) begin
            // The link cannot stall, so a missing word goes out as zeros.
            w_fifo_rd   = !fifo_empty;
            w_load_data = fifo_empty ? 32'h0 : fifo_data;
            w_load_strb = w_sched_strb;
            w_underrun  = fifo_empty;
            w_dec       = 1'b1;
          end else begin
            w_done       = 1'b1;
            w_clr_ready  = 1'b1;
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_words_left <= '0;
      r_rem        <= 2'b00;
      r_data       <= 32'h0;
      r_strb       <= 4'b0000;
      r_word_ready <= 1'b0;
      r_pkt_done   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pkt_done <= w_done;
      if (w_latch) begin
        r_words_left <= w_len_words;
        r_rem        <= pkt_len[1:0];
        r_underflow  <= 1'b0;
      end else if (w_dec) begin
        r_words_left <= r_words_left - WL_W'(1);
      end
      if (w_load) begin
        r_data <= w_load_data;
        r_strb <= w_load_strb;
      end
      if (w_set_ready) begin
        r_word_ready <= 1'b1;
      end else if (w_clr_ready) begin
        r_word_ready <= 1'b0;
      end
      if (w_underrun) begin
        r_underflow <= 1'b1;
      end
    end
  end

`ifdef DSI_FEEDER_UNDERFLOW_CNT_EN
  logic [15:0] r_underflow_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_underflow_cnt <= 16'h0;
    end else if (w_underrun && (r_underflow_cnt != 16'hFFFF)) begin
      r_underflow_cnt <= r_underflow_cnt + 16'h1;
    end
  end

  assign underflow_cnt = r_underflow_cnt;
`endif

  assign fifo_rd    = w_fifo_rd;
  assign pkt_busy   = (r_state != IDLE);
  assign word_ready = r_word_ready;
  assign pkt_done   = r_pkt_done;
  assign underflow  = r_underflow;
  assign data_out   = r_data;
  assign strb_out   = r_strb;

endmodule

`default_nettype wire

// File: tb/tb_dsi_payload_feeder.sv
// ============================================================================
// tb_dsi_payload_feeder : directed and randomized packets vs. a packet-level model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dsi_payload_feeder;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pkt_start = 1'b0;
  logic [LEN_W-1:0] pkt_len = '0;
  logic             pkt_busy;
  logic             word_ready;
  logic             pkt_done;
  logic             underflow;
  logic [31:0]      fifo_data = 32'h0;
  logic             fifo_empty = 1'b1;
  logic             fifo_rd;
  logic             data_change_req = 1'b0;
  logic [31:0]      data_out;
  logic [3:0]       strb_out;
`ifdef DSI_FEEDER_UNDERFLOW_CNT_EN
  logic [15:0]      underflow_cnt;
`endif

  dsi_payload_feeder #(.LEN_W(LEN_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pkt_start       (pkt_start),
    .pkt_len         (pkt_len),
    .pkt_busy        (pkt_busy),
    .word_ready      (word_ready),
    .pkt_done        (pkt_done),
    .underflow       (underflow),
`ifdef DSI_FEEDER_UNDERFLOW_CNT_EN
    .underflow_cnt   (underflow_cnt),
`endif
    .fifo_data       (fifo_data),
    .fifo_empty      (fifo_empty),
    .fifo_rd         (fifo_rd),
    .data_change_req (data_change_req),
    .data_out        (data_out),
    .strb_out        (strb_out)
  );

  always #5 clk = ~clk;

  logic [31:0] fifo_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          rd_cnt   = 0;
  logic        exp_uf   = 1'b0;
  int          exp_uf_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Show-ahead FIFO view; an empty head shows junk so zero substitution is visible.
  task automatic refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 32'hDEAD_BEEF : fifo_q[0];
  endtask

  task automatic push(input logic [31:0] w);
    fifo_q.push_back(w);
    refresh();
  endtask

  task automatic step();
    logic rd;
    #1;
    rd = fifo_rd;
    if (rd) rd_cnt++;
    @(posedge clk);
    if (rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
    #1;
    refresh();
  endtask

  // Expected lane mask of payload word k: one bit per byte still remaining.
  function automatic logic [3:0] exp_strb(input int len, input int k);
    int left;
    left = len - 4 * k;
    if (left >= 4) return 4'hF;
    return 4'((1 << left) - 1);
  endfunction

  task automatic check_outs(input string tag, input logic [31:0] d, input logic [3:0] s,
                            input logic wr, input logic busy, input logic done);
    check({tag, ".data"}, data_out, d);
    check({tag, ".strb"}, {28'h0, strb_out}, {28'h0, s});
    check({tag, ".ready"}, {31'h0, word_ready}, {31'h0, wr});
    check({tag, ".busy"}, {31'h0, pkt_busy}, {31'h0, busy});
    check({tag, ".done"}, {31'h0, pkt_done}, {31'h0, done});
    check({tag, ".uflow"}, {31'h0, underflow}, {31'h0, exp_uf});
`ifdef DSI_FEEDER_UNDERFLOW_CNT_EN
    check({tag, ".ucnt"}, {16'h0, underflow_cnt}, exp_uf_cnt);
`endif
  endtask

  task automatic run_packet(input int len, input logic [31:0] miss, input int fill_delay,
                            input bit intrude);
    int          n;
    int          rd0;
    int          exp_rd;
    int          gaps;
    logic [31:0] w;
    n      = (len + 3) / 4;
    rd0    = rd_cnt;
    exp_rd = 0;
    pkt_start = 1'b1;
    pkt_len   = LEN_W'(len);
    step();
    pkt_start = 1'b0;
    pkt_len   = LEN_W'($urandom);
    exp_uf    = 1'b0;
    check_outs("start", 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    repeat (fill_delay) begin
      step();
      check_outs("fill_wait", 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    end
    w = $urandom;
    push(w);
    step();
    exp_rd++;
    check_outs("word0", w, exp_strb(len, 0), 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= n; k++) begin
      gaps = $urandom_range(intrude ? 1 : 0, 2);
      repeat (gaps) begin
        if (intrude) begin
          pkt_start = 1'b1;
          pkt_len   = LEN_W'(len + 4 + $urandom_range(0, 20));
        end
        step();
        pkt_start = 1'b0;
        check_outs("hold", w, exp_strb(len, k - 1), 1'b1, 1'b1, 1'b0);
      end
      if (k < n) begin
        if (miss[k]) begin
          w = 32'h0;
          exp_uf = 1'b1;
          if (exp_uf_cnt < 65535) exp_uf_cnt++;
        end else begin
          w = $urandom;
          push(w);
          exp_rd++;
        end
        data_change_req = 1'b1;
        step();
        data_change_req = 1'b0;
        check_outs("word", w, exp_strb(len, k), 1'b1, 1'b1, 1'b0);
      end else begin
        data_change_req = 1'b1;
        step();
        data_change_req = 1'b0;
        check_outs("end", 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
      end
    end
    step();
    check_outs("post", 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    check("rd_count", rd_cnt - rd0, exp_rd);
  endtask

  initial begin
    int r0;
    refresh();
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    check("reset.fifo_rd", {31'h0, fifo_rd}, 32'h0);
    rst_n = 1'b1;

    run_packet(8, 32'h0, 0, 1'b0);
    run_packet(5, 32'h0, 2, 1'b0);

    r0 = rd_cnt;
    pkt_start = 1'b1;
    pkt_len   = '0;
    step();
    pkt_start = 1'b0;
    check_outs("len0", 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    step();
    check_outs("len0.post", 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    check("len0.rd_count", rd_cnt - r0, 0);

    run_packet(12, 32'h2, 0, 1'b0);
    run_packet(20, 32'h0, 1, 1'b1);

    // Reset in the middle of a 12-byte packet, then a clean 4-byte packet.
    pkt_start = 1'b1;
    pkt_len   = LEN_W'(12);
    step();
    pkt_start = 1'b0;
    push(32'h1111_2222);
    step();
    push(32'h3333_4444);
    data_change_req = 1'b1;
    step();
    data_change_req = 1'b0;
    check("midrst.pre", data_out, 32'h3333_4444);
    rst_n = 1'b0;
    exp_uf = 1'b0;
    exp_uf_cnt = 0;
    #1;
    check_outs("midrst", 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    check("midrst.fifo_rd", {31'h0, fifo_rd}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    refresh();
    run_packet(4, 32'h0, 0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      run_packet($urandom_range(1, 40), $urandom & $urandom & $urandom,
                 $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dsi_payload_feeder.md
Name: dsi_payload_feeder

Overview:
Producer side of the 32-bit word / 4-bit lane-strobe interface consumed by the lane repacker.
- Pulls packet payload words from a show-ahead FIFO.
- Presents one registered word plus a per-byte-lane valid strobe, and advances on each data_change_req.
- Strobes drop to 0 after the last payload byte so the repacker detects end-of-data per lane.
- Sits between the packet assembler payload FIFO and the repacker in the HS transmit path.

Parameters:
LEN_W, 16, width of packet payload byte length.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
pkt_start  in  1  one-cycle pulse; latch pkt_len and begin a packet
pkt_len  in  LEN_W  payload length in bytes
pkt_busy  out  1  packet in progress (FILL or ACTIVE)
word_ready  out  1  first word loaded; repacker may be enabled
pkt_done  out  1  one-cycle pulse at packet end
underflow  out  1  sticky: FIFO empty when a payload word was needed
fifo_data  in  32  show-ahead FIFO head word
fifo_empty  in  1  FIFO empty
fifo_rd  out  1  pop FIFO head this cycle
data_change_req  in  1  repacker consumed current word; load next word at this edge
data_out  out  32  current word (byte i = lane i)
strb_out  out  4  per-byte valid mask of data_out

Behaviour:
- Reset: state IDLE; data_out=0, strb_out=0, fifo_rd=0, pkt_busy=0, word_ready=0, pkt_done=0, underflow=0, all counters 0.
- Registers:
  - words_left = ceil(pkt_len/4), LEN_W-1 bits.
  - rem = pkt_len[1:0].
  - Last-word mask: rem 0→1111, 1→0001, 2→0011, 3→0111.
  - All other payload words: 1111.
- IDLE:
  - pkt_start with pkt_len!=0: latch length, clear underflow, go FILL.
  - pkt_start with pkt_len==0: pkt_done=1 next cycle, stay IDLE, no fifo_rd.
  - data_change_req: reload data_out=0, strb_out=0.
- FILL:
  - fifo_rd=!fifo_empty (combinational).
  - On pop: data_out<=fifo_data; strb_out<=(words_left==1 ? last mask : 1111); words_left--; word_ready<=1; go ACTIVE.
  - Waits indefinitely while the FIFO is empty.
  - data_change_req is ignored; the upstream controller must not enable the repacker before word_ready.
- ACTIVE, on data_change_req:
  - words_left!=0:
    - fifo_rd=!fifo_empty.
    - Load fifo_data, or 0 if empty and set underflow.
    - Strobe per schedule; words_left--.
    - Timing never stalls: HS transmission cannot pause.
  - words_left==0: load data_out=0, strb_out=0; pulse pkt_done next cycle; word_ready<=0; go IDLE.
- fifo_rd is never asserted outside FILL/ACTIVE, and never more than once per word.
- pkt_busy=1 in FILL and ACTIVE.
- pkt_start while pkt_busy: ignored; no relatch.
- Latency:
  - pkt_start at edge N: FILL from N+1.
  - With FIFO non-empty, data_out/word_ready valid after edge N+2.
- Reset mid-packet: immediate return to reset values. The FIFO is not flushed; that is the owner's responsibility.

Optional Feature:
DSI_FEEDER_UNDERFLOW_CNT_EN
- Defined: adds output underflow_cnt [15:0].
  - Counts every zero-substituted word; saturates at 16'hFFFF.
  - Cleared by reset only.
- Undefined: port and counter absent; the sticky underflow flag is unchanged.

Decomposition:
- Package dsi_feeder_pkg:
  - State enum {IDLE, FILL, ACTIVE}.
  - Constant STRB_FULL=4'b1111.
  - Function last_strb(rem[1:0]) returning the last-word mask.
- No sub-module; a single flat module.

Test Plan:
- pkt_len=8, FIFO holds A,B; req every cycle:
  - data_out/strb_out sequence A/1111, B/1111, 0/0000.
  - pkt_done one cycle later; exactly 2 fifo_rd.
- pkt_len=5:
  - strb sequence 1111, 0001, 0000.
  - Repacker lanes 1-3 end on word 0 and lane 0 ends on word 1.
- pkt_len=0:
  - pkt_done pulse one cycle after pkt_start.
  - fifo_rd never asserted; pkt_busy stays 0.
- pkt_len=12 with the FIFO empty before the 2nd req:
  - Second word is 0/1111 with underflow=1.
  - Third word taken from FIFO; underflow held until the next pkt_start.
  - With the macro defined, underflow_cnt=1.
- pkt_start while ACTIVE with a different pkt_len: ignored; original word count completes.
- rst_n asserted mid-ACTIVE, then a new pkt_len=4: all outputs 0 immediately; the new packet runs cleanly as 1111, 0000.
